// File: rtl/vga_sym_grid_gen.sv
// vga_sym_grid_gen: character-grid position generator for the debug text screen.
// Advances one pixel per active-pixel strobe. It produces the pixel-in-glyph
// position, the symbol column and row, and the char-RAM address. It supports
// ring-buffer vertical scroll and emits line and frame pulses.
// Optional blinking cursor: define VGA_CURSOR_EN to build it in. Without the
// macro, cursor_on is tied low.
module vga_sym_grid_gen #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30,
  localparam int PXW = $clog2(GLYPH_W),
  localparam int PYW = $clog2(GLYPH_H),
  localparam int CXW = $clog2(COLS),
  localparam int CYW = $clog2(ROWS),
  localparam int AW  = $clog2(COLS * ROWS)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           en,
  input  logic           frame_start,
  input  logic           scroll_we,
  input  logic [CYW-1:0] scroll_row,
  input  logic [CXW-1:0] cursor_x,
  input  logic [CYW-1:0] cursor_y,
  output logic [PXW-1:0] pix_x,
  output logic [PYW-1:0] pix_y,
  output logic [CXW-1:0] sym_x,
  output logic [CYW-1:0] sym_y,
  output logic [AW-1:0]  disp_addr,
  output logic           line_end,
  output logic           frame_end,
  output logic           cursor_on
);

  localparam logic [PXW-1:0] LAST_PX  = PXW'(GLYPH_W - 1);
  localparam logic [PYW-1:0] LAST_PY  = PYW'(GLYPH_H - 1);
  localparam logic [CXW-1:0] LAST_SX  = CXW'(COLS - 1);
  localparam logic [CYW-1:0] LAST_SY  = CYW'(ROWS - 1);
  localparam logic [CYW:0]   ROWS_W   = (CYW + 1)'(ROWS);
  localparam logic [AW:0]    COLS_W   = (AW + 1)'(COLS);
  localparam logic [AW:0]    SCREEN_W = (AW + 1)'(COLS * ROWS);

  logic [PXW-1:0] pix_x_q, pix_x_d;
  logic [PYW-1:0] pix_y_q, pix_y_d;
  logic [CXW-1:0] sym_x_q, sym_x_d;
  logic [CYW-1:0] sym_y_q, sym_y_d;
  logic [AW-1:0]  row_base_q, row_base_d;
  logic           line_end_q, line_end_d;
  logic           frame_end_q, frame_end_d;
  logic [CYW-1:0] scroll_pend_q, scroll_pend_d;
  logic [AW-1:0]  scroll_base_q, scroll_base_d;
  logic           frame_wrap;
  logic [AW:0]    row_sum;
  logic [AW-1:0]  row_step;

  // Base address of the next text row, wrapping around the ring buffer.
  // Extra MSB keeps the sum exact even when COLS*ROWS is a power of two.
  assign row_sum  = {1'b0, row_base_q} + COLS_W;
  assign row_step = (row_sum >= SCREEN_W) ? '0 : row_sum[AW-1:0];

  // Next-state logic for the pixel/symbol counters and the line/frame pulses.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    sym_x_d     = sym_x_q;
    sym_y_d     = sym_y_q;
    row_base_d  = row_base_q;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    frame_wrap  = 1'b0;
    if (frame_start) begin
      pix_x_d    = '0;
      pix_y_d    = '0;
      sym_x_d    = '0;
      sym_y_d    = '0;
      row_base_d = scroll_base_q;
    end else if (en) begin
      if (pix_x_q == LAST_PX) begin
        pix_x_d = '0;
        if (sym_x_q == LAST_SX) begin
          sym_x_d    = '0;
          line_end_d = 1'b1;
          if (pix_y_q == LAST_PY) begin
            pix_y_d = '0;
            if (sym_y_q == LAST_SY) begin
              sym_y_d     = '0;
              frame_end_d = 1'b1;
              frame_wrap  = 1'b1;
              row_base_d  = scroll_base_q;
            end else begin
              sym_y_d    = sym_y_q + 1'b1;
              row_base_d = row_step;
            end
          end else begin
            pix_y_d = pix_y_q + 1'b1;
          end
        end else begin
          sym_x_d = sym_x_q + 1'b1;
        end
      end else begin
        pix_x_d = pix_x_q + 1'b1;
      end
    end
  end

  // Scroll pipeline: latch a valid row, then multiply it into a base address one cycle later.
  always_comb begin
    scroll_pend_d = scroll_pend_q;
    if (scroll_we && ({1'b0, scroll_row} < ROWS_W)) begin
      scroll_pend_d = scroll_row;
    end
    scroll_base_d = AW'(scroll_pend_q * COLS);
  end

  // State registers for counters, pulses and scroll.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      sym_x_q       <= '0;
      sym_y_q       <= '0;
      row_base_q    <= '0;
      line_end_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      scroll_pend_q <= '0;
      scroll_base_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      sym_x_q       <= sym_x_d;
      sym_y_q       <= sym_y_d;
      row_base_q    <= row_base_d;
      line_end_q    <= line_end_d;
      frame_end_q   <= frame_end_d;
      scroll_pend_q <= scroll_pend_d;
      scroll_base_q <= scroll_base_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign sym_x     = sym_x_q;
  assign sym_y     = sym_y_q;
  assign disp_addr = row_base_q + AW'(sym_x_q);
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`ifdef VGA_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]  LAST_BLINK = BW'(BLINK_FRAMES - 1);
  localparam logic [PYW-1:0] CURSOR_PY  = PYW'(GLYPH_H - 2);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_vis_q, blink_vis_d;

  // Blink phase: count completed frames and flip visibility every BLINK_FRAMES of them.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (frame_wrap) begin
      if (blink_cnt_q == LAST_BLINK) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink state registers; the cursor starts visible after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end

  assign cursor_on = (sym_x_q == cursor_x) && (sym_y_q == cursor_y) &&
                     (pix_y_q >= CURSOR_PY) && blink_vis_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y, frame_wrap, 32'(BLINK_FRAMES)};
  assign cursor_on     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sym_grid_gen.sv
// Self-checking bench for vga_sym_grid_gen, built with a small grid so full frames stay short.
// The reference model tracks a linear pixel index per frame plus the scroll row latched at each
// frame boundary, and derives every output arithmetically from those two numbers.
module tb_vga_sym_grid_gen;

  localparam int GW = 4, GH = 4, NC = 5, NR = 6, BF = 3;
  localparam int LINE  = GW * NC;
  localparam int FRAME = LINE * GH * NR;

  logic       clk, resetn, en, frame_start, scroll_we;
  logic [2:0] scroll_row, cursor_x, cursor_y, sym_x, sym_y;
  logic [1:0] pix_x, pix_y;
  logic [4:0] disp_addr;
  logic       line_end, frame_end, cursor_on;

  vga_sym_grid_gen #(
    .GLYPH_W(GW), .GLYPH_H(GH), .COLS(NC), .ROWS(NR), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .frame_start(frame_start),
    .scroll_we(scroll_we), .scroll_row(scroll_row),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .pix_x(pix_x), .pix_y(pix_y), .sym_x(sym_x), .sym_y(sym_y),
    .disp_addr(disp_addr), .line_end(line_end), .frame_end(frame_end),
    .cursor_on(cursor_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_p, m_frame_row, m_sb_row, m_frames, cyc;
  bit m_le, m_fe;
  int wq_val[$];
  int wq_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scroll row that a frame boundary at the current edge would latch: only writes
  // accepted at least two edges earlier have reached the base address.
  function automatic int eligible_row();
    while (wq_cyc.size() > 0 && wq_cyc[0] <= cyc - 2) begin
      m_sb_row = wq_val.pop_front();
      void'(wq_cyc.pop_front());
    end
    return m_sb_row;
  endfunction

  task automatic model_reset();
    m_p = 0; m_frame_row = 0; m_sb_row = 0; m_frames = 0;
    m_le = 0; m_fe = 0;
    wq_val.delete(); wq_cyc.delete();
  endtask

  task automatic compare_model();
    int px, sx, py, sy, addr;
    bit cur;
    px   = m_p % GW;
    sx   = (m_p / GW) % NC;
    py   = (m_p / LINE) % GH;
    sy   = m_p / (LINE * GH);
    addr = ((m_frame_row + sy) % NR) * NC + sx;
`ifdef VGA_CURSOR_EN
    cur = (((m_frames / BF) % 2) == 0) && (sx == int'(cursor_x)) &&
          (sy == int'(cursor_y)) && (py >= GH - 2);
`else
    cur = 1'b0;
`endif
    check("pix_x", pix_x, px);
    check("sym_x", sym_x, sx);
    check("pix_y", pix_y, py);
    check("sym_y", sym_y, sy);
    check("disp_addr", disp_addr, addr);
    check("line_end", line_end, m_le);
    check("frame_end", frame_end, m_fe);
    check("cursor_on", cursor_on, cur);
  endtask

  // One clock: drive inputs now (away from the edge), advance the model at the edge, compare after it.
  task automatic step(input bit e, input bit fs, input bit we, input int row);
    en = e; frame_start = fs; scroll_we = we; scroll_row = 3'(row);
    @(posedge clk);
    cyc++;
    m_le = 0; m_fe = 0;
    if (fs) begin
      m_p = 0;
      m_frame_row = eligible_row();
    end else if (e) begin
      if (m_p % LINE == LINE - 1) m_le = 1;
      if (m_p == FRAME - 1) begin
        m_fe = 1; m_p = 0; m_frames++;
        m_frame_row = eligible_row();
      end else begin
        m_p++;
      end
    end
    if (we && row < NR) begin
      wq_val.push_back(row);
      wq_cyc.push_back(cyc);
    end
    #1;
    compare_model();
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    en = 0; frame_start = 0; scroll_we = 0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    resetn = 1'b1;
  endtask

  typedef struct {
    int n;
    bit e;
    int px, sx, py, sy, addr;
    bit le, fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hits;
    vecs[0] = '{3,   1'b1, 3, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{1,   1'b1, 0, 1, 0, 0, 1, 1'b0, 1'b0};
    vecs[2] = '{15,  1'b1, 3, 4, 0, 0, 4, 1'b0, 1'b0};
    vecs[3] = '{1,   1'b1, 0, 0, 1, 0, 0, 1'b1, 1'b0};
    vecs[4] = '{2,   1'b0, 0, 0, 1, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{60,  1'b1, 0, 0, 0, 1, 5, 1'b1, 1'b0};
    vecs[6] = '{400, 1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b1};
    vecs[7] = '{1,   1'b1, 1, 0, 0, 0, 0, 1'b0, 1'b0};

    en = 0; frame_start = 0; scroll_we = 0; scroll_row = 0;
    cursor_x = 3'd3; cursor_y = 3'd2; resetn = 1'b0; cyc = 0;
    model_reset();
    #12;
    do_reset();
    check("reset_addr", disp_addr, 0);

`ifdef VGA_CURSOR_EN
    // Cursor at (3,2): 8 lit pixels per visible frame, none in the blanked frames.
    for (int f = 0; f < 2 * BF; f++) begin
      hits = 0;
      for (int i = 0; i < FRAME; i++) begin
        step(1'b1, 1'b0, 1'b0, 0);
        if (cursor_on === 1'b1) hits++;
      end
      check("cursor_hits", hits, (f < BF) ? 8 : 0);
    end
    do_reset();
`endif

    // Directed walk through the grid from reset.
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) step(vecs[k].e, 1'b0, 1'b0, 0);
      check("vec_pix_x", pix_x, vecs[k].px);
      check("vec_sym_x", sym_x, vecs[k].sx);
      check("vec_pix_y", pix_y, vecs[k].py);
      check("vec_sym_y", sym_y, vecs[k].sy);
      check("vec_addr", disp_addr, vecs[k].addr);
      check("vec_line_end", line_end, vecs[k].le);
      check("vec_frame_end", frame_end, vecs[k].fe);
    end

    // Scroll to row 5 mid-frame: no effect until the frame boundary, then ring wrap.
    step(1'b1, 1'b0, 1'b1, 5);            // p = 2
    run_en(98);                           // p = 100, screen row 1
    check("scroll_midframe_addr", disp_addr, 5);
    run_en(FRAME - 100);                  // wrap
    check("scroll_row0_addr", disp_addr, 25);
    check("scroll_frame_end", frame_end, 1);
    run_en(80);                           // screen row 1 -> text row 0
    check("scroll_ringwrap_addr", disp_addr, 0);

    // Out-of-range scroll row is dropped.
    step(1'b1, 1'b0, 1'b1, 7);            // p = 81
    run_en(FRAME - 81);
    check("scroll_drop_addr", disp_addr, 25);

    // frame_start on the last pixel of a line: origin, no pulses.
    run_en(LINE - 1);
    step(1'b1, 1'b1, 1'b0, 0);
    check("fs_pix_x", pix_x, 0);
    check("fs_line_end", line_end, 0);
    check("fs_frame_end", frame_end, 0);
    check("fs_addr", disp_addr, 25);

    // Write in the wrap cycle, then in the cycle before a wrap: both miss that wrap.
    run_en(FRAME - 1);
    step(1'b1, 1'b0, 1'b1, 2);
    check("we_at_wrap_addr", disp_addr, 25);
    run_en(FRAME - 2);
    step(1'b1, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 0);
    check("we_before_wrap_addr", disp_addr, 10);
    run_en(FRAME);
    check("we_late_applied_addr", disp_addr, 5);

    // Reset mid-frame returns to origin with scroll cleared.
    run_en(37);
    do_reset();
    check("midreset_sym_x", sym_x, 0);
    run_en(FRAME);
    check("midreset_scroll_addr", disp_addr, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        cursor_x = 3'($urandom_range(0, NC - 1));
        cursor_y = 3'($urandom_range(0, NR - 1));
      end
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 699) == 0),
           ($urandom_range(0, 49) == 0), int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
